// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, write-lane masks
// and the two-state read-modify-write sequencer.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_e;

  // Size 2'b11 is treated as a full word.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return MASK_B;
      SZ_HALF: return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// EX/MEM request, data-memory port and MEM/WB result bundle of the load/store unit.
// The slave modport is the LSU; the master side is the pipeline plus the data memory.
interface mem_stage_lsu_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          req_valid;
  logic          req_load;
  logic          req_store;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [RW-1:0] req_rd;
  logic          flush;
  logic          stall;

  logic          dm_ce;
  logic          dm_we;
  logic          dm_memRr;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wtData;
  logic [3:0]    dm_w_mask;
  logic [3:0]    dm_r_mask;
  logic [DW-1:0] dm_rdData;

  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          misalign_exc;
  logic [DW-1:0] exc_addr;

  modport slave (
    input  req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata, req_rd,
           flush, dm_rdData,
    output stall, dm_ce, dm_we, dm_memRr, dm_addr, dm_wtData, dm_w_mask, dm_r_mask,
           wb_valid, wb_rd, wb_data, misalign_exc, exc_addr
  );

  modport master (
    output req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata, req_rd,
           flush, dm_rdData,
    input  stall, dm_ce, dm_we, dm_memRr, dm_addr, dm_wtData, dm_w_mask, dm_r_mask,
           wb_valid, wb_rd, wb_data, misalign_exc, exc_addr
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: right-aligns and extends load data, and merges store lanes into
// a previously read word for read-modify-write.
module mem_lane_align
  import mips_mem_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rd_data,
  input  logic [DW-1:0] wdata,
  input  logic [1:0]    offset,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  output logic [DW-1:0] load_data,
  output logic [DW-1:0] merge_data
);

  logic [DW-1:0] rd_shift;
  logic [DW-1:0] wd_shift;
  logic [DW-1:0] lane_bits;
  logic [3:0]    lane_mask;

  always_comb begin
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it
    // unassigned; a missed branch would otherwise infer a latch.
    lane_bits = '0;
    rd_shift  = rd_data >> {offset, 3'b000};
    wd_shift  = wdata << {offset, 3'b000};
    lane_mask = size_mask(size) << offset;
    for (int i = 0; i < 4; i++) lane_bits[8*i +: 8] = {8{lane_mask[i]}};

    case (size)
      SZ_BYTE: load_data = {{(DW-8){sign_ext & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: load_data = {{(DW-16){sign_ext & rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase

    merge_data = (rd_data & ~lane_bits) | (wd_shift & lane_bits);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: decodes EX/MEM requests into data-memory controls, runs
// read-modify-write for offset sub-word stores and registers results into MEM/WB.
module mem_stage_lsu
  import mips_mem_pkg::*;
#(
  parameter int DW         = 32,
  parameter int RW         = 5,
  parameter bit RMW_ENABLE = 1'b1
) (
  input logic            clk,
  input logic            rst,
  mem_stage_lsu_if.slave bus
);

  lsu_state_e    state;
  logic [DW-1:0] merge_q;
  logic [DW-1:0] load_data;
  logic [DW-1:0] merge_data;
  logic [DW-1:0] word_addr;
  logic [1:0]    offset;
  logic          is_word, is_half, sub_off;
  logic          has_req, misaligned, go;
  logic          do_load, do_store, do_rmw_rd, raise_exc;

  assign offset    = bus.req_addr[1:0];
  assign word_addr = {bus.req_addr[DW-1:2], 2'b00};
  assign is_word   = bus.req_size[1];
  assign is_half   = (bus.req_size == SZ_HALF);
  assign sub_off   = !is_word && (offset != 2'b00);
  assign has_req   = bus.req_valid && (bus.req_load || bus.req_store);

  // Without RMW support, an offset sub-word store cannot be expressed with low-lane masks.
  assign misaligned = (is_half && offset[0]) || (is_word && offset != 2'b00) ||
                      (!RMW_ENABLE && bus.req_store && sub_off);

  assign go        = (state == IDLE) && has_req && !bus.flush && !misaligned;
  assign do_load   = go && bus.req_load;
  assign do_store  = go && bus.req_store && !sub_off;
  assign do_rmw_rd = go && bus.req_store && sub_off;
  assign raise_exc = (state == IDLE) && has_req && !bus.flush && misaligned;

  mem_lane_align #(.DW(DW)) u_align (
    .rd_data    (bus.dm_rdData),
    .wdata      (bus.req_wdata),
    .offset     (offset),
    .size       (bus.req_size),
    .sign_ext   (bus.req_signed),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    bus.dm_ce     = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_memRr  = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wtData = '0;
    bus.dm_w_mask = '0;
    bus.dm_r_mask = '0;
    bus.stall     = 1'b0;
    // Everything facing memory and upstream is silenced while reset is held.
    if (!rst) begin
      if (state == RMW_WR) begin
        bus.dm_ce     = 1'b1;
        bus.dm_we     = !bus.flush;
        bus.dm_addr   = word_addr;
        bus.dm_wtData = merge_q;
        bus.dm_w_mask = MASK_W;
        bus.dm_r_mask = MASK_W;
      end else if (do_load || do_rmw_rd) begin
        bus.dm_ce     = 1'b1;
        bus.dm_memRr  = 1'b1;
        bus.dm_addr   = word_addr;
        bus.dm_r_mask = MASK_W;
        bus.stall     = do_rmw_rd;
      end else if (do_store) begin
        bus.dm_ce     = 1'b1;
        bus.dm_we     = 1'b1;
        bus.dm_addr   = word_addr;
        bus.dm_wtData = bus.req_wdata;
        bus.dm_w_mask = size_mask(bus.req_size);
        bus.dm_r_mask = MASK_W;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      merge_q          <= '0;
      bus.wb_valid     <= 1'b0;
      bus.wb_rd        <= '0;
      bus.wb_data      <= '0;
      bus.misalign_exc <= 1'b0;
      bus.exc_addr     <= '0;
    end else begin
      bus.wb_valid     <= do_load;
      bus.misalign_exc <= raise_exc;
      if (do_load) begin
        bus.wb_rd   <= bus.req_rd;
        bus.wb_data <= load_data;
      end
      if (raise_exc) bus.exc_addr <= bus.req_addr;
      case (state)
        IDLE: begin
          if (do_rmw_rd) begin
            merge_q <= merge_data;
            state   <= RMW_WR;
          end
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: behavioural data memory, scoreboard of expected
// load write-backs, and one task per scenario.
module tb_mem_stage_lsu;
  import mips_mem_pkg::*;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  logic [31:0] mem [64];
  wb_exp_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  mem_stage_lsu_if #(.DW(32), .RW(5)) bus ();

  mem_stage_lsu #(.DW(32), .RW(5), .RMW_ENABLE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, lane-masked write on the rising edge.
  assign bus.dm_rdData = mem[bus.dm_addr[7:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'h8899AABB;
      mem[8]  <= 32'hCAFEF00D;
      mem[12] <= 32'h11223344;
    end else if (bus.dm_ce && bus.dm_we) begin
      for (int i = 0; i < 4; i++)
        if (bus.dm_w_mask[i]) mem[bus.dm_addr[7:2]][8*i +: 8] <= bus.dm_wtData[8*i +: 8];
    end
  end

  // Scoreboard: every write-back must match the oldest expected load result.
  always @(negedge clk) begin
    if (!rst && bus.wb_valid === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: wb_rd=%0d wb_data=%h, none expected", bus.wb_rd, bus.wb_data);
      end else begin
        wb_exp_t e;
        e = sb_q.pop_front();
        if ({bus.wb_rd, bus.wb_data} !== {e.rd, e.data}) begin
          n_err++;
          $display("FAIL wb_data: got rd=%0d data=%h, expected rd=%0d data=%h",
                   bus.wb_rd, bus.wb_data, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic set_req(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd);
    bus.req_valid  = v;
    bus.req_load   = ld;
    bus.req_store  = st;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
  endtask

  task automatic go_idle();
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.flush = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [4:0] rd, input logic [31:0] exp, input string name);
    wb_exp_t e;
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b0, sz, sg, a, 32'h0, rd);
    #1;
    n_cmp++;
    if ({bus.dm_ce, bus.dm_memRr, bus.dm_we, bus.stall, bus.dm_r_mask, bus.dm_addr} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, a[31:2], 2'b00}) begin
      n_err++;
      $display("FAIL %s_ctrl: ce=%b rr=%b we=%b stall=%b rmask=%b addr=%h", name, bus.dm_ce,
               bus.dm_memRr, bus.dm_we, bus.stall, bus.dm_r_mask, bus.dm_addr);
    end
    e.rd = rd;
    e.data = exp;
    sb_q.push_back(e);
    @(posedge clk); #1;
    n_cmp++;
    if (bus.wb_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_latency: wb_valid=%b, expected 1 one cycle after request", name, bus.wb_valid);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                          input logic [3:0] exp_mask, input logic [31:0] exp_word, input string name);
    @(negedge clk);
    set_req(1'b1, 1'b0, 1'b1, sz, 1'b0, a, wd, 5'd0);
    #1;
    n_cmp++;
    if ({bus.dm_ce, bus.dm_we, bus.dm_memRr, bus.stall, bus.dm_w_mask, bus.dm_wtData} !==
        {1'b1, 1'b1, 1'b0, 1'b0, exp_mask, wd}) begin
      n_err++;
      $display("FAIL %s_ctrl: ce=%b we=%b rr=%b stall=%b wmask=%b wdata=%h, expected wmask=%b wdata=%h",
               name, bus.dm_ce, bus.dm_we, bus.dm_memRr, bus.stall, bus.dm_w_mask, bus.dm_wtData,
               exp_mask, wd);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.wb_valid !== 1'b0 || mem[a[7:2]] !== exp_word) begin
      n_err++;
      $display("FAIL %s_mem: wb_valid=%b mem=%h, expected 0 / %h", name, bus.wb_valid,
               mem[a[7:2]], exp_word);
    end
  endtask

  // Offset sub-word store: read cycle with stall, then write cycle (optionally flushed).
  task automatic do_rmw(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                        input logic fl, input logic [31:0] exp_merge, input logic [31:0] exp_word,
                        input string name);
    @(negedge clk);
    set_req(1'b1, 1'b0, 1'b1, sz, 1'b0, a, wd, 5'd0);
    #1;
    n_cmp++;
    if ({bus.stall, bus.dm_ce, bus.dm_memRr, bus.dm_we} !== 4'b1110) begin
      n_err++;
      $display("FAIL %s_read: stall=%b ce=%b rr=%b we=%b, expected 1 1 1 0", name, bus.stall,
               bus.dm_ce, bus.dm_memRr, bus.dm_we);
    end
    @(posedge clk); #1;
    bus.flush = fl;
    #1;
    n_cmp++;
    if ({bus.stall, bus.dm_ce, bus.dm_we, bus.dm_memRr, bus.dm_w_mask} !== {1'b0, 1'b1, !fl, 1'b0, 4'b1111} ||
        (!fl && bus.dm_wtData !== exp_merge)) begin
      n_err++;
      $display("FAIL %s_write: stall=%b ce=%b we=%b rr=%b wmask=%b wdata=%h, expected we=%b wdata=%h",
               name, bus.stall, bus.dm_ce, bus.dm_we, bus.dm_memRr, bus.dm_w_mask, bus.dm_wtData,
               !fl, exp_merge);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.wb_valid !== 1'b0 || mem[a[7:2]] !== exp_word) begin
      n_err++;
      $display("FAIL %s_mem: wb_valid=%b mem=%h, expected 0 / %h", name, bus.wb_valid,
               mem[a[7:2]], exp_word);
    end
  endtask

  task automatic do_misalign(input logic ld, input logic [1:0] sz, input logic [31:0] a,
                             input string name);
    @(negedge clk);
    set_req(1'b1, ld, !ld, sz, 1'b0, a, 32'hFFFF_FFFF, 5'd3);
    #1;
    n_cmp++;
    if ({bus.dm_ce, bus.dm_we, bus.stall} !== 3'b000) begin
      n_err++;
      $display("FAIL %s_ce: ce=%b we=%b stall=%b, expected 0 0 0", name, bus.dm_ce, bus.dm_we, bus.stall);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.misalign_exc, bus.wb_valid, bus.exc_addr} !== {1'b1, 1'b0, a}) begin
      n_err++;
      $display("FAIL %s_exc: exc=%b wb_valid=%b exc_addr=%h, expected 1 0 %h", name,
               bus.misalign_exc, bus.wb_valid, bus.exc_addr, a);
    end
    go_idle();
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.misalign_exc, bus.exc_addr} !== {1'b0, a}) begin
      n_err++;
      $display("FAIL %s_pulse: exc=%b exc_addr=%h, expected 0 %h (held)", name,
               bus.misalign_exc, bus.exc_addr, a);
    end
  endtask

  task automatic test_reset();
    // Traffic presented while reset is held must produce nothing.
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5'd7);
    #1;
    n_cmp++;
    if ({bus.dm_ce, bus.dm_we, bus.dm_memRr, bus.stall, bus.dm_w_mask, bus.dm_r_mask,
         bus.dm_addr, bus.dm_wtData, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.misalign_exc,
         bus.exc_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ce=%b we=%b rr=%b stall=%b addr=%h wb_valid=%b wb_data=%h exc=%b",
               bus.dm_ce, bus.dm_we, bus.dm_memRr, bus.stall, bus.dm_addr, bus.wb_valid,
               bus.wb_data, bus.misalign_exc);
    end
    // Start an RMW store, then hit reset while it sits in the write cycle.
    @(negedge clk);
    rst = 1'b0;
    set_req(1'b1, 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h31, 32'h77, 5'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.dm_ce, bus.dm_we, bus.stall, bus.wb_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_rmw: ce=%b we=%b stall=%b wb_valid=%b, expected all 0",
               bus.dm_ce, bus.dm_we, bus.stall, bus.wb_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem[12] !== 32'h11223344) begin
      n_err++;
      $display("FAIL reset_no_write: mem[0x30]=%h, expected 11223344", mem[12]);
    end
    @(negedge clk);
    rst = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    do_load(32'h10, SZ_WORD, 1'b0, 5'd7, 32'h8899AABB, "post_reset_lw");
    go_idle();
  endtask

  task automatic test_loads();
    do_load(32'h12, SZ_BYTE, 1'b1, 5'd1, 32'hFFFFFF99, "lb");
    do_load(32'h12, SZ_BYTE, 1'b0, 5'd2, 32'h00000099, "lbu");
    do_load(32'h12, SZ_HALF, 1'b1, 5'd3, 32'hFFFF8899, "lh");
    do_load(32'h10, SZ_WORD, 1'b0, 5'd4, 32'h8899AABB, "lw");
    do_load(32'h10, SZ_HALF, 1'b0, 5'd5, 32'h0000AABB, "lhu_lo");
    do_load(32'h13, SZ_BYTE, 1'b0, 5'd0, 32'h00000088, "lbu_rd0");
    go_idle();
  endtask

  task automatic test_rmw_store();
    do_rmw(32'h11, SZ_BYTE, 32'h5A, 1'b0, 32'h88995ABB, 32'h88995ABB, "sb_rmw");
    go_idle();
    do_load(32'h11, SZ_BYTE, 1'b0, 5'd6, 32'h0000005A, "lbu_after_rmw");
    go_idle();
  endtask

  task automatic test_single_store();
    do_store(32'h20, SZ_HALF, 32'hDEAD1234, MASK_H, 32'hCAFE1234, "sh_off0");
    do_store(32'h24, SZ_WORD, 32'hA5A5A5A5, MASK_W, 32'hA5A5A5A5, "sw");
    do_store(32'h30, SZ_BYTE, 32'h00000066, MASK_B, 32'h11223366, "sb_off0");
    go_idle();
    do_load(32'h24, SZ_WORD, 1'b0, 5'd8, 32'hA5A5A5A5, "lw_after_sw");
    go_idle();
  endtask

  task automatic test_misalign();
    do_misalign(1'b1, SZ_WORD, 32'h22, "lw_0x22");
    do_misalign(1'b1, SZ_HALF, 32'h21, "lh_0x21");
    do_misalign(1'b0, SZ_WORD, 32'h27, "sw_0x27");
  endtask

  task automatic test_flush();
    do_rmw(32'h13, SZ_BYTE, 32'hEE, 1'b1, 32'hEE995ABB, 32'h88995ABB, "sb_flush");
    bus.flush = 1'b0;
    do_load(32'h10, SZ_WORD, 1'b0, 5'd9, 32'h88995ABB, "lw_after_flush");
    // Flushed load in IDLE is not performed and produces no write-back.
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.dm_ce !== 1'b0) begin
      n_err++;
      $display("FAIL flush_load_ce: dm_ce=%b, expected 0", bus.dm_ce);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.wb_valid, bus.wb_data} !== {1'b0, 32'h88995ABB}) begin
      n_err++;
      $display("FAIL flush_load_wb: wb_valid=%b wb_data=%h, expected 0 88995ABB (held)",
               bus.wb_valid, bus.wb_data);
    end
    go_idle();
  endtask

  initial begin
    bus.flush = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    test_reset();
    test_loads();
    test_rmw_store();
    test_single_store();
    test_misalign();
    test_flush();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected write-backs never arrived", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
